// File: rtl/eh2_dccm_scrubber_if.sv
// DCCM port bundle between the background scrubber and the LSU arbiter / DCCM.
// The master side issues req/rden/wren; the slave side grants and returns read data.
interface eh2_dccm_scrubber_if #(
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_FDATA_WIDTH = 39
);
  logic                        scrub_req;
  logic                        scrub_gnt;
  logic                        dccm_rden;
  logic                        dccm_wren;
  logic [DCCM_BITS-1:0]        dccm_rd_addr_lo;
  logic [DCCM_BITS-1:0]        dccm_rd_addr_hi;
  logic [DCCM_BITS-1:0]        dccm_wr_addr_lo;
  logic [DCCM_BITS-1:0]        dccm_wr_addr_hi;
  logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo;
  logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_hi;
  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo;

  modport master (
    output scrub_req, dccm_rden, dccm_wren,
    output dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_addr_lo, dccm_wr_addr_hi,
    output dccm_wr_data_lo, dccm_wr_data_hi,
    input  scrub_gnt, dccm_rd_data_lo
  );

  modport slave (
    input  scrub_req, dccm_rden, dccm_wren,
    input  dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_addr_lo, dccm_wr_addr_hi,
    input  dccm_wr_data_lo, dccm_wr_data_hi,
    output scrub_gnt, dccm_rd_data_lo
  );
endinterface

// File: rtl/eh2_dccm_scrubber.sv
// Background DCCM ECC scrubber: walks every word, writes back single-bit corrections,
// logs double-bit errors. Uses the 32+7 SECDED layout {ecc[6:0], data[31:0]}.
module eh2_dccm_scrubber #(
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_FDATA_WIDTH = 39,
  parameter int INTERVAL_W       = 16,
  parameter int CNT_W            = 16
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  scrub_en,
  input  logic                  dec_tlu_core_ecc_disable,
  input  logic [INTERVAL_W-1:0] scrub_interval,
  eh2_dccm_scrubber_if.master   dccm,
  output logic                  scrub_sb_err,
  output logic                  scrub_db_err,
  output logic [DCCM_BITS-1:0]  scrub_err_addr,
  output logic [CNT_W-1:0]      scrub_sb_cnt,
  output logic [CNT_W-1:0]      scrub_db_cnt,
  output logic                  scrub_pass_done
);

  localparam int IDX_W = DCCM_BITS - 2;

  // Hamming codeword position of each data bit (powers of two hold check bits).
  localparam logic [5:0] DATA_POS [32] = '{
    6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15,
    6'd17, 6'd18, 6'd19, 6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27,
    6'd28, 6'd29, 6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
  };

  function automatic logic [5:0] hamming(input logic [31:0] d);
    logic [5:0] h;
    h = '0;
    for (int j = 0; j < 32; j++) begin
      for (int k = 0; k < 6; k++) begin
        if (DATA_POS[j][k]) h[k] = h[k] ^ d[j];
      end
    end
    return h;
  endfunction

  function automatic logic [6:0] ecc_gen(input logic [31:0] d);
    logic [5:0] h;
    h = hamming(d);
    return {^{d, h}, h};
  endfunction

  typedef enum logic [2:0] {StIdle, StWait, StRreq, StCheck, StWreq} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [INTERVAL_W-1:0] cnt_q, cnt_d;
  logic [31:0]           fix_q, fix_d;
  logic [DCCM_BITS-1:0]  err_addr_q, err_addr_d;
  logic [CNT_W-1:0]      sb_cnt_q, sb_cnt_d, db_cnt_q, db_cnt_d;

  logic                 active, advance;
  logic [DCCM_BITS-1:0] byte_addr;
  logic [38:0]          rd_word;
  logic [5:0]           syndrome;
  logic                 parity_err, sb_hit, db_hit;
  logic [31:0]          corrected;

  assign active    = scrub_en & ~dec_tlu_core_ecc_disable;
  assign byte_addr = {idx_q, 2'b00};

  // SECDED decode: odd overall parity means one flipped bit, even parity with a
  // non-zero syndrome means two.
  assign rd_word    = dccm.dccm_rd_data_lo;
  assign syndrome   = hamming(rd_word[31:0]) ^ rd_word[37:32];
  assign parity_err = ^rd_word;
  assign sb_hit     = parity_err;
  assign db_hit     = ~parity_err & (syndrome != 6'd0);

  always_comb begin
    corrected = rd_word[31:0];
    for (int j = 0; j < 32; j++) begin
      if (DATA_POS[j] == syndrome) corrected[j] = ~rd_word[j];
    end
  end

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    cnt_d           = cnt_q;
    fix_d           = fix_q;
    err_addr_d      = err_addr_q;
    sb_cnt_d        = sb_cnt_q;
    db_cnt_d        = db_cnt_q;
    advance         = 1'b0;
    dccm.scrub_req  = 1'b0;
    dccm.dccm_rden  = 1'b0;
    dccm.dccm_wren  = 1'b0;
    scrub_sb_err    = 1'b0;
    scrub_db_err    = 1'b0;
    scrub_pass_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (active) begin
          cnt_d   = scrub_interval;
          state_d = StWait;
        end
      end
      StWait: begin
        if (!active)              state_d = StIdle;
        else if (cnt_q == '0)     state_d = StRreq;
        else                      cnt_d   = cnt_q - 1'b1;
      end
      StRreq: begin
        if (!active) begin
          state_d = StIdle;
        end else begin
          dccm.scrub_req = 1'b1;
          dccm.dccm_rden = dccm.scrub_gnt;
          if (dccm.scrub_gnt) state_d = StCheck;
        end
      end
      StCheck: begin
        if (sb_hit) begin
          scrub_sb_err = 1'b1;
          err_addr_d   = byte_addr;
          fix_d        = corrected;
          if (!(&sb_cnt_q)) sb_cnt_d = sb_cnt_q + 1'b1;
          state_d      = StWreq;
        end else begin
          if (db_hit) begin
            scrub_db_err = 1'b1;
            err_addr_d   = byte_addr;
            if (!(&db_cnt_q)) db_cnt_d = db_cnt_q + 1'b1;
          end
          advance = 1'b1;
        end
      end
      StWreq: begin
        // A correction already read must land even if scrubbing was just disabled.
        dccm.scrub_req = 1'b1;
        dccm.dccm_wren = dccm.scrub_gnt;
        if (dccm.scrub_gnt) advance = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (advance) begin
      idx_d           = idx_q + 1'b1;
      scrub_pass_done = &idx_q;
      cnt_d           = scrub_interval;
      state_d         = active ? StWait : StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cnt_q      <= '0;
      fix_q      <= '0;
      err_addr_q <= '0;
      sb_cnt_q   <= '0;
      db_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      fix_q      <= fix_d;
      err_addr_q <= err_addr_d;
      sb_cnt_q   <= sb_cnt_d;
      db_cnt_q   <= db_cnt_d;
    end
  end

  assign dccm.dccm_rd_addr_lo = byte_addr;
  assign dccm.dccm_rd_addr_hi = byte_addr;
  assign dccm.dccm_wr_addr_lo = byte_addr;
  assign dccm.dccm_wr_addr_hi = byte_addr;
  assign dccm.dccm_wr_data_lo = {ecc_gen(fix_q), fix_q};
  assign dccm.dccm_wr_data_hi = {ecc_gen(fix_q), fix_q};

  assign scrub_err_addr = err_addr_q;
  assign scrub_sb_cnt   = sb_cnt_q;
  assign scrub_db_cnt   = db_cnt_q;

endmodule

// File: tb/tb_eh2_dccm_scrubber.sv
// Directed bench for eh2_dccm_scrubber: a 64-word DCCM model with a SECDED encoder,
// a vector table of injected faults, and hand-written corner-case sequences.
module tb_eh2_dccm_scrubber;
  localparam int AW = 8;
  localparam int FW = 39;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_l;
  logic          scrub_en, ecc_dis;
  logic [15:0]   scrub_interval;
  logic          sb_err, db_err, pass_done;
  logic [AW-1:0] err_addr;
  logic [CW-1:0] sb_cnt, db_cnt;

  eh2_dccm_scrubber_if #(.DCCM_BITS(AW), .DCCM_FDATA_WIDTH(FW)) bus ();

  eh2_dccm_scrubber #(.DCCM_BITS(AW), .DCCM_FDATA_WIDTH(FW), .INTERVAL_W(16), .CNT_W(CW)) dut (
    .clk                      (clk),
    .rst_l                    (rst_l),
    .scrub_en                 (scrub_en),
    .dec_tlu_core_ecc_disable (ecc_dis),
    .scrub_interval           (scrub_interval),
    .dccm                     (bus),
    .scrub_sb_err             (sb_err),
    .scrub_db_err             (db_err),
    .scrub_err_addr           (err_addr),
    .scrub_sb_cnt             (sb_cnt),
    .scrub_db_cnt             (db_cnt),
    .scrub_pass_done          (pass_done)
  );

  always #5 clk = ~clk;

  // DCCM model: one-cycle read latency; tb pokes share the write port process.
  logic [FW-1:0] mem [64];
  logic          poke_req = 1'b0;
  logic [5:0]    poke_idx;
  logic [FW-1:0] poke_val;
  always @(posedge clk) begin
    if (bus.dccm_rden) bus.dccm_rd_data_lo <= mem[bus.dccm_rd_addr_lo[7:2]];
    if (bus.dccm_wren) mem[bus.dccm_wr_addr_lo[7:2]] <= bus.dccm_wr_data_lo;
    if (poke_req) mem[poke_idx] <= poke_val;
  end

  int cyc = 0, sb_pulses = 0, db_pulses = 0, pass_cnt = 0, wren_cnt = 0, viol = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rst_l) begin
      sb_pulses <= sb_pulses + int'(sb_err);
      db_pulses <= db_pulses + int'(db_err);
      pass_cnt  <= pass_cnt + int'(pass_done);
      wren_cnt  <= wren_cnt + int'(bus.dccm_wren);
      if ((bus.dccm_rden && bus.dccm_wren) || (bus.dccm_rden && !bus.scrub_gnt) ||
          (bus.dccm_wren && !bus.scrub_gnt)) viol <= viol + 1;
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference SECDED encoder: builds the Hamming codeword explicitly.
  function automatic logic [FW-1:0] enc(input logic [31:0] d);
    logic [38:0] cw;
    logic [6:0]  e;
    int          n;
    cw = '0;
    n  = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[n];
        n++;
      end
    end
    e = '0;
    for (int k = 0; k < 6; k++)
      for (int p = 1; p <= 38; p++)
        if (((p >> k) & 1) == 1) e[k] = e[k] ^ cw[p];
    e[6] = (^d) ^ (^e[5:0]);
    return {e, d};
  endfunction

  function automatic logic [31:0] dat(input int i);
    return 32'hC3A5_1E70 ^ (32'(i) * 32'h0101_0101);
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == {CW{1'b1}}) ? c : c + 1'b1;
  endfunction

  task automatic poke(input int idx, input logic [FW-1:0] val);
    poke_idx = 6'(idx);
    poke_val = val;
    poke_req = 1'b1;
    @(posedge clk);
    #1 poke_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_rden(input logic [AW-1:0] addr, input bit any, input int budget,
                           output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.dccm_rden && (any || bus.dccm_rd_addr_lo == addr)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_wren(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.dccm_wren) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    int          idx;
    logic [38:0] flip;
    bit          exp_sb;
    bit          exp_db;
  } vec_t;

  vec_t          vecs [7];
  bit            ok, flag;
  int            t0, wr_before, sb_base;
  logic [CW-1:0] m_sb, m_db;
  logic [AW-1:0] a;

  initial begin
    vecs[0] = '{idx: 4,  flip: 39'h1 << 5,                  exp_sb: 1, exp_db: 0};
    vecs[1] = '{idx: 8,  flip: (39'h1 << 3) | (39'h1 << 9), exp_sb: 0, exp_db: 1};
    vecs[2] = '{idx: 10, flip: 39'h1 << 34,                 exp_sb: 1, exp_db: 0};
    vecs[3] = '{idx: 12, flip: 39'h1 << 38,                 exp_sb: 1, exp_db: 0};
    vecs[4] = '{idx: 14, flip: 39'h0,                       exp_sb: 0, exp_db: 0};
    vecs[5] = '{idx: 20, flip: 39'h1 << 31,                 exp_sb: 1, exp_db: 0};
    vecs[6] = '{idx: 22, flip: (39'h1 << 0) | (39'h1 << 32), exp_sb: 0, exp_db: 1};
    m_sb = '0;
    m_db = '0;

    rst_l = 1'b0; scrub_en = 1'b0; ecc_dis = 1'b0; scrub_interval = 16'd2;
    bus.scrub_gnt = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req", bus.scrub_req, 0);
    chk("rst_rden", bus.dccm_rden, 0);
    chk("rst_wren", bus.dccm_wren, 0);
    chk("rst_sb_cnt", sb_cnt, 0);
    chk("rst_db_cnt", db_cnt, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_pass_done", pass_done, 0);
    chk("rst_rd_addr", bus.dccm_rd_addr_lo, 0);
    rst_l = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 64; i++) poke(i, enc(dat(i)));
    foreach (vecs[v]) poke(vecs[v].idx, enc(dat(vecs[v].idx)) ^ vecs[v].flip);

    // Clean walk start: access period with interval 2 is five cycles.
    scrub_en = 1'b1;
    wait_rden(8'h04, 0, 60, ok);
    chk("first_rd_0x04", ok, 1);
    t0 = cyc;
    @(negedge clk);
    wait_rden(8'h08, 0, 60, ok);
    chk("rd_0x08", ok, 1);
    chk("period", 64'(cyc - t0), 5);
    chk("rd_addr_hi", bus.dccm_rd_addr_hi, 8'h08);

    foreach (vecs[v]) begin
      a = 8'(vecs[v].idx * 4);
      wait_rden(a, 0, 400, ok);
      chk($sformatf("v%0d_rden", v), ok, 1);
      wr_before = wren_cnt;
      @(negedge clk);
      chk($sformatf("v%0d_sb_err", v), sb_err, vecs[v].exp_sb);
      chk($sformatf("v%0d_db_err", v), db_err, vecs[v].exp_db);
      if (vecs[v].exp_sb) m_sb = sat_inc(m_sb);
      if (vecs[v].exp_db) m_db = sat_inc(m_db);
      @(negedge clk);
      if (vecs[v].exp_sb || vecs[v].exp_db) chk($sformatf("v%0d_err_addr", v), err_addr, a);
      chk($sformatf("v%0d_sb_cnt", v), sb_cnt, m_sb);
      chk($sformatf("v%0d_db_cnt", v), db_cnt, m_db);
      if (vecs[v].exp_sb) begin
        wait_wren(30, ok);
        chk($sformatf("v%0d_wren", v), ok, 1);
        chk($sformatf("v%0d_wr_addr", v), bus.dccm_wr_addr_lo, a);
        chk($sformatf("v%0d_wr_addr_hi", v), bus.dccm_wr_addr_hi, a);
        chk($sformatf("v%0d_wr_data", v), bus.dccm_wr_data_lo, enc(dat(vecs[v].idx)));
        chk($sformatf("v%0d_wr_data_hi", v), bus.dccm_wr_data_hi, enc(dat(vecs[v].idx)));
      end else begin
        @(negedge clk);
        wait_rden(8'(a + 8'd4), 0, 30, ok);
        chk($sformatf("v%0d_next_rd", v), ok, 1);
        chk($sformatf("v%0d_no_write", v), 64'(wren_cnt - wr_before), 0);
      end
    end

    // Wrap back to word 0: exactly one pass_done, only the injected errors seen.
    wait_rden(8'h00, 0, 600, ok);
    chk("wrap_rd_0", ok, 1);
    chk("pass_done_cnt", 64'(pass_cnt), 1);
    chk("sb_pulses", 64'(sb_pulses), 4);
    chk("db_pulses", 64'(db_pulses), 2);
    chk("bus_violations", 64'(viol), 0);

    // Disable while requesting: no access, word index kept at 0.
    scrub_en = 1'b0;
    #1 chk("dis_rreq_rden", bus.dccm_rden, 0);
    @(negedge clk);
    poke(8, enc(dat(8)));
    poke(22, enc(dat(22)));
    flag = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.scrub_req) flag = 1'b0;
    end
    chk("idle_no_req", flag, 1);

    // Grant withheld: req held, rden low, then rden in the same cycle as gnt.
    bus.scrub_gnt = 1'b0;
    scrub_en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      ok = bus.scrub_req;
    end
    chk("req_seen", ok, 1);
    flag = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!bus.scrub_req || bus.dccm_rden) flag = 1'b0;
    end
    chk("gnt_hold", flag, 1);
    bus.scrub_gnt = 1'b1;
    #1 chk("gnt_rden", bus.dccm_rden, 1);
    chk("gnt_resume_addr", bus.dccm_rd_addr_lo, 8'h00);
    @(negedge clk);

    // Drop enable in CHECK of a single-bit word: writeback still lands, then idle.
    poke(2, enc(dat(2)) ^ (39'h1 << 17));
    wait_rden(8'h08, 0, 40, ok);
    chk("en_drop_rd", ok, 1);
    @(negedge clk);
    scrub_en = 1'b0;
    chk("en_drop_sb_err", sb_err, 1);
    m_sb = sat_inc(m_sb);
    @(negedge clk);
    wait_wren(10, ok);
    chk("en_drop_wren", ok, 1);
    chk("en_drop_wr_addr", bus.dccm_wr_addr_lo, 8'h08);
    chk("en_drop_wr_data", bus.dccm_wr_data_lo, enc(dat(2)));
    flag = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.scrub_req || bus.dccm_rden || bus.dccm_wren) flag = 1'b0;
    end
    chk("en_drop_idle", flag, 1);
    chk("en_drop_sb_cnt", sb_cnt, m_sb);
    scrub_en = 1'b1;
    wait_rden(8'h00, 1, 40, ok);
    chk("reenable_rd", ok, 1);
    chk("reenable_addr", bus.dccm_rd_addr_lo, 8'h0C);

    // Saturation: five more single-bit words push the 3-bit counter past all-ones.
    sb_base = sb_pulses;
    for (int i = 5; i <= 9; i++) poke(i, enc(dat(i)) ^ (39'h1 << (i + 1)));
    for (int i = 0; i < 5; i++) m_sb = sat_inc(m_sb);
    wait_rden(8'h28, 0, 200, ok);
    chk("sat_rd", ok, 1);
    chk("sat_pulses", 64'(sb_pulses - sb_base), 5);
    chk("sat_sb_cnt", sb_cnt, m_sb);
    chk("sat_db_cnt", db_cnt, m_db);
    chk("sat_err_addr", err_addr, 8'h24);
    chk("sat_violations", 64'(viol), 0);

    // Asynchronous reset mid-walk clears counters and drops any request.
    @(negedge clk);
    #2 rst_l = 1'b0;
    #1;
    chk("arst_sb_cnt", sb_cnt, 0);
    chk("arst_db_cnt", db_cnt, 0);
    chk("arst_req", bus.scrub_req, 0);
    chk("arst_rd_addr", bus.dccm_rd_addr_lo, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
